byte_packer: RTL and testbench
==============================

BYTE_PACKER -- requirements
Module: byte_packer

Interface
REQ-001 SHALL have parameter InW, default 8, meaning input lane width in bits.
REQ-002 SHALL have parameter OutW, default 32, meaning output word width in bits; OutW SHALL be an integer multiple of InW, and Lanes = OutW/InW SHALL be >= 2.
REQ-003 SHALL have clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have clr_i  input  1  synchronous clear of all packing state.
REQ-006 SHALL have valid_i  input  1  input lane valid.
REQ-007 SHALL have ready_o  output  1  input lane accepted when valid_i & ready_o.
REQ-008 SHALL have data_i  input  InW  input lane data.
REQ-009 SHALL have last_i  input  1  accepted lane closes the current word, whether or not it is complete.
REQ-010 SHALL have valid_o  output  1  packed word valid.
REQ-011 SHALL have ready_i  input  1  downstream accepts the word when valid_o & ready_i.
REQ-012 SHALL have data_o  output  OutW  packed word; lane k occupies bits [k*InW +: InW].
REQ-013 SHALL have mask_o  output  Lanes  per-lane valid mask, contiguous from bit 0.
REQ-014 SHALL have last_o  output  1  word was closed by last_i.

Function
REQ-015 SHALL hold one accumulating word, a lane index (clog2(Lanes) bits), an accumulated mask and one output word register.
REQ-016 SHALL write each accepted lane into lane index position, set that mask bit, and increment the index.
REQ-017 SHALL close the word when the accepted lane is in position Lanes-1 or last_i=1, and reset the index to 0.
REQ-018 SHALL load a closed word into the output register with valid_o=1 in the cycle after the closing lane is accepted (latency 1).
REQ-019 SHALL drive ready_o = ~valid_o | ready_i, sustaining one lane per cycle under continuous ready_i.
REQ-020 SHALL, on simultaneous output handshake and word close, load the new word and keep valid_o=1.
REQ-021 SHALL hold data_o, mask_o and last_o stable while valid_o=1 and ready_i=0.
REQ-022 SHALL deassert valid_o after a handshake with no new word closing.
REQ-023 SHALL produce mask_o=1 and last_o=1 when last_i is set on the first lane of a word.
REQ-024 SHALL never emit a word with mask_o=0; lanes are accepted only via valid_i.
REQ-025 SHALL, on clr_i=1, discard the accumulating word and the pending output, then deassert valid_o, zero the index and mask, and ignore valid_i that cycle; clr_i SHALL take priority over all other events.

Reset
REQ-026 SHALL, on rst_ni=0, force valid_o=0, data_o=0, mask_o=0, last_o=0, index=0 and accumulated mask=0 immediately, independent of clk_i.
REQ-027 SHALL drive ready_o=1 after reset (valid_o=0).

Configuration
REQ-028 SHALL, with macro BYTE_PACKER_ZERO_PAD_EN defined, drive zero in data_o lanes whose mask_o bit is 0.
REQ-029 SHALL, without BYTE_PACKER_ZERO_PAD_EN, leave unmasked data_o lanes holding the accumulator's previous contents; mask_o, valid_o and timing SHALL be identical in both builds.

Structure
REQ-030 SHALL take the Lanes computation, the lane-index width function and a packed-word struct (data, mask, last) from the shared package byte_packer_pkg.
REQ-031 SHALL be a single flat module with no sub-module; the lane counter is too small to justify one.

Verification
REQ-032 Bench SHALL cover: bytes 0x11,0x22,0x33,0x44 back-to-back, ready_i=1 -> data_o=0x44332211, mask_o=0xF, last_o=0, valid_o one cycle after 0x44.
REQ-033 Bench SHALL cover: bytes 0xAA,0xBB with last_i on 0xBB -> mask_o=0x3, last_o=1, data_o[31:16]=0 with BYTE_PACKER_ZERO_PAD_EN.
REQ-034 Bench SHALL cover: 8 bytes with ready_i=0 held until the first word is valid -> ready_o=0 while stalled; both words delivered in order, no lane lost or duplicated.
REQ-035 Bench SHALL cover: single byte 0x5A with last_i on the first lane -> mask_o=0x1, last_o=1, data_o[7:0]=0x5A.
REQ-036 Bench SHALL cover: clr_i pulsed after 2 accepted bytes and with a word pending -> valid_o=0 next cycle; the following 4 bytes form a fresh word with mask_o=0xF.
REQ-037 Bench SHALL cover: rst_ni asserted mid-word with valid_o=1 -> all outputs 0 asynchronously and ready_o=1 after release.

Source files
------------

// File: rtl/byte_packer_pkg.sv
// Shared definitions for the byte packer: lane geometry helpers and the
// packed output word (data, per-lane mask, last flag).
package byte_packer_pkg;

    localparam int unsigned PkgInW  = 8;
    localparam int unsigned PkgOutW = 32;

    // Number of input lanes that make up one output word.
    function automatic int unsigned lanes_f(input int unsigned in_w, input int unsigned out_w);
        return out_w / in_w;
    endfunction

    // Width of the lane index counter; never narrower than one bit.
    function automatic int unsigned idx_w_f(input int unsigned lanes);
        return (lanes < 2) ? 1 : $clog2(lanes);
    endfunction

    localparam int unsigned PkgLanes = lanes_f(PkgInW, PkgOutW);

    typedef struct packed {
        logic [PkgOutW-1:0]  data;
        logic [PkgLanes-1:0] mask;
        logic                last;
    } word_t;

endpackage

// File: rtl/byte_packer.sv
// Byte packer: gathers InW-bit input lanes into an OutW-bit word, lane 0 in
// the least significant position. A word closes when its top lane is filled
// or when last_i arrives, and is presented one cycle later on a
// valid/ready output register. Lanes are accepted one per cycle while the
// output register is empty or being drained.
// Optional build macro: BYTE_PACKER_ZERO_PAD_EN -- forces data_o lanes whose
// mask bit is clear to zero; otherwise those lanes carry whatever the
// accumulator last held in that position.
module byte_packer
    import byte_packer_pkg::*;
#(
    parameter int unsigned InW  = PkgInW,
    parameter int unsigned OutW = PkgOutW
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clr_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [InW-1:0]                data_i,
    input  logic                          last_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [OutW-1:0]               data_o,
    output logic [lanes_f(InW,OutW)-1:0]  mask_o,
    output logic                          last_o
);

    localparam int unsigned Lanes = lanes_f(InW, OutW);
    localparam int unsigned IdxW  = idx_w_f(Lanes);

    // The shared word struct is sized for the package geometry, so the
    // instance geometry has to match it.
    if ((OutW % InW) != 0 || Lanes < 2 || InW != PkgInW || OutW != PkgOutW) begin : g_bad_cfg
        $error("byte_packer: unsupported InW/OutW combination");
    end

    logic [OutW-1:0]  r_acc;
    logic [IdxW-1:0]  r_idx;
    logic [Lanes-1:0] r_mask;
    word_t            r_out;
    logic             r_vld;

    logic             w_accept;
    logic             w_close;
    logic [OutW-1:0]  w_acc_nxt;
    logic [Lanes-1:0] w_mask_nxt;
    word_t            w_word;

    assign ready_o  = ~r_vld | ready_i;
    assign w_accept = valid_i & ready_o & ~clr_i;
    assign w_close  = w_accept & (last_i | (r_idx == IdxW'(Lanes - 1)));

    // Accumulator and mask as they look with the current lane merged in.
    always_comb begin
        w_acc_nxt  = r_acc;
        w_mask_nxt = r_mask;
        for (int k = 0; k < Lanes; k++) begin
            if (r_idx == IdxW'(k)) begin
                w_acc_nxt[k*InW +: InW] = data_i;
                w_mask_nxt[k]           = 1'b1;
            end
        end
    end

    // Word presented to the output register when the current lane closes it.
    always_comb begin
        w_word.mask = w_mask_nxt;
        w_word.last = last_i;
`ifdef BYTE_PACKER_ZERO_PAD_EN
        for (int k = 0; k < Lanes; k++) begin
            w_word.data[k*InW +: InW] = w_mask_nxt[k] ? w_acc_nxt[k*InW +: InW] : '0;
        end
`else
        w_word.data = w_acc_nxt;
`endif
    end

    // Lane data storage; stale lanes are deliberately left in place.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc <= '0;
        end else if (w_accept) begin
            r_acc <= w_acc_nxt;
        end
    end

    // Lane index and accumulated mask; both restart on close or clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idx  <= '0;
            r_mask <= '0;
        end else if (clr_i || w_close) begin
            r_idx  <= '0;
            r_mask <= '0;
        end else if (w_accept) begin
            r_idx  <= r_idx + 1'b1;
            r_mask <= w_mask_nxt;
        end
    end

    // Output register: clear wins, then a closing word, then drain on ready.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out <= '0;
            r_vld <= 1'b0;
        end else if (clr_i) begin
            r_vld <= 1'b0;
        end else if (w_close) begin
            r_out <= w_word;
            r_vld <= 1'b1;
        end else if (ready_i) begin
            r_vld <= 1'b0;
        end
    end

    assign valid_o = r_vld;
    assign data_o  = r_out.data;
    assign mask_o  = r_out.mask;
    assign last_o  = r_out.last;

endmodule

// File: tb/tb_byte_packer.sv
// Testbench for byte_packer (InW=8, OutW=32): directed scenarios plus a
// randomized run, checked by a scoreboard fed from a lane-list model.
module tb_byte_packer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        clr_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [7:0]  data_i = '0;
    logic        last_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] data_o;
    logic [3:0]  mask_o;
    logic        last_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [31:0] lmask;
        logic [3:0]  mask;
        logic        last;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] cur[$];
    bit         rnd_on;

    byte_packer #(.InW(8), .OutW(32)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clr_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .last_i  (last_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .mask_o  (mask_o),
        .last_o  (last_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // Scoreboard + reference model, evaluated mid-cycle.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            chk("valid_o", valid_o, exp_q.size() != 0);
            chk("ready_o", ready_o, (exp_q.size() == 0) || ready_i);
            if (valid_o && ready_i && !clr_i) begin
                if (exp_q.size() == 0) begin
                    fail_timeout("unexpected word");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
`ifdef BYTE_PACKER_ZERO_PAD_EN
                    chk("sb data_o", data_o, e.data);
`else
                    chk("sb data_o", data_o & e.lmask, e.data);
`endif
                    chk("sb mask_o", mask_o, e.mask);
                    chk("sb last_o", last_o, e.last);
                end
            end
            if (clr_i) begin
                exp_q.delete();
                cur.delete();
            end else if (valid_i && ready_o) begin
                cur.push_back(data_i);
                if (cur.size() == 4 || last_i) begin
                    exp_t e;
                    e.data  = '0;
                    e.lmask = '0;
                    for (int k = 0; k < cur.size(); k++) begin
                        e.data  = e.data | (32'(cur[k]) << (8 * k));
                        e.lmask = e.lmask | (32'hFF << (8 * k));
                    end
                    e.mask = 4'((1 << cur.size()) - 1);
                    e.last = last_i;
                    exp_q.push_back(e);
                    cur.delete();
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        valid_i = 1'b1;
        data_i  = d;
        last_i  = l;
        n = 0;
        forever begin
            @(negedge clk_i);
            if (ready_o) break;
            n++;
            if (n > 200) begin
                fail_timeout("send");
                break;
            end
        end
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 || valid_o) begin
            @(negedge clk_i);
            n++;
            if (n > 200) begin
                fail_timeout("drain");
                break;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_clr();
        clr_i   = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'hEE;
        @(posedge clk_i);
        #1;
        clr_i   = 1'b0;
        valid_i = 1'b0;
        chk("clr valid_o", valid_o, 1'b0);
    endtask

    initial begin
        #1 rst_ni = 1'b0;
        #1;
        chk("rst valid_o", valid_o, 1'b0);
        chk("rst data_o", data_o, 32'h0);
        chk("rst mask_o", mask_o, 4'h0);
        chk("rst last_o", last_o, 1'b0);
        chk("rst ready_o", ready_o, 1'b1);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        idle(1);

        // Four bytes back-to-back with ready_i high.
        ready_i = 1'b1;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        chk("full valid_o before close", valid_o, 1'b0);
        send(8'h44, 1'b0);
        chk("full valid_o after close", valid_o, 1'b1);
        chk("full data_o", data_o, 32'h44332211);
        chk("full mask_o", mask_o, 4'hF);
        chk("full last_o", last_o, 1'b0);

        // Short word closed by last_i.
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b1);
        chk("short mask_o", mask_o, 4'h3);
        chk("short last_o", last_o, 1'b1);
        chk("short data_o lo", data_o[15:0], 16'hBBAA);
`ifdef BYTE_PACKER_ZERO_PAD_EN
        chk("short data_o pad", data_o[31:16], 16'h0000);
`else
        chk("short data_o stale", data_o[31:16], 16'h4433);
`endif

        // Single lane with last_i.
        send(8'h5A, 1'b1);
        chk("single mask_o", mask_o, 4'h1);
        chk("single last_o", last_o, 1'b1);
        chk("single data_o", data_o[7:0], 8'h5A);
        drain();

        // Stalled output: eight bytes, ready_i low until the first word shows.
        ready_i = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(8'h80 + 8'(i), 1'b0);
            end
            begin
                int n;
                logic [31:0] snap;
                n = 0;
                while (!valid_o && n < 100) begin
                    @(negedge clk_i);
                    n++;
                end
                if (!valid_o) fail_timeout("stall first word");
                snap = data_o;
                repeat (3) begin
                    @(negedge clk_i);
                    chk("stall ready_o", ready_o, 1'b0);
                    chk("stall data_o held", data_o, snap);
                end
                @(posedge clk_i);
                #1 ready_i = 1'b1;
            end
        join
        drain();

        // Clear with a word pending.
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h60 + 8'(i), 1'b0);
        chk("pend valid_o", valid_o, 1'b1);
        pulse_clr();
        ready_i = 1'b1;

        // Clear after two accepted lanes, then a fresh full word.
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        pulse_clr();
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        send(8'hC3, 1'b0);
        send(8'hC4, 1'b0);
        chk("post clr mask_o", mask_o, 4'hF);
        chk("post clr data_o", data_o, 32'hC4C3C2C1);
        drain();

        // Randomized traffic with random downstream back-pressure.
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    idle($urandom_range(0, 2));
                    send(8'($urandom), $urandom_range(0, 4) == 0);
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk_i);
                    #1 ready_i = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ready_i = 1'b1;
        drain();

        // Asynchronous reset with a word pending.
        ready_i = 1'b0;
        send(8'h71, 1'b0);
        send(8'h72, 1'b1);
        chk("pre rst valid_o", valid_o, 1'b1);
        #2 rst_ni = 1'b0;
        exp_q.delete();
        cur.delete();
        #1;
        chk("arst valid_o", valid_o, 1'b0);
        chk("arst data_o", data_o, 32'h0);
        chk("arst mask_o", mask_o, 4'h0);
        chk("arst last_o", last_o, 1'b0);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        ready_i = 1'b0;
        @(negedge clk_i);
        chk("post rst ready_o", ready_o, 1'b1);
        @(posedge clk_i);
        #1 ready_i = 1'b1;
        send(8'hD1, 1'b0);
        send(8'hD2, 1'b0);
        send(8'hD3, 1'b0);
        send(8'hD4, 1'b0);
        chk("post rst mask_o", mask_o, 4'hF);
        chk("post rst data_o", data_o, 32'hD4D3D2D1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout at %0t", $time);
        $fatal(1, "global timeout");
    end

endmodule
